// File: rtl/adc_pkg.sv
// Shared types and default constants for the multi-channel ADC sample scheduler.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int          HEAD_W        = 10;
  localparam int          MAX_DEPTH     = 1024;
  localparam int          DEF_DEPTH     = 640;
  localparam int          DEF_DEPTH_W   = $clog2(DEF_DEPTH);
  localparam logic [11:0] DEF_BASE_ADDR = 12'h800;
  localparam int          DEF_INTERVAL  = 175000;

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable tick generator: free-running counter that pulses tick_o once per interval.
module sample_tick_gen
  import adc_pkg::*;
#(
  parameter int INTERVAL_W   = 18,
  parameter int INTERVAL_DEF = DEF_INTERVAL
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  interval_we_i,
  input  logic [INTERVAL_W-1:0] interval_in_i,
  output logic                  tick_o
);

  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [INTERVAL_W-1:0] count_q, count_d;
  logic [INTERVAL_W-1:0] period;
  logic                  wrap;

  // Periods below 2 are clamped; >= also recovers if the interval shrinks below the count.
  always_comb begin
    period     = (interval_q < INTERVAL_W'(2)) ? INTERVAL_W'(2) : interval_q;
    wrap       = (count_q >= period - INTERVAL_W'(1));
    tick_o     = enable_i && !interval_we_i && wrap;
    interval_d = interval_q;
    count_d    = count_q;
    if (interval_we_i) begin
      interval_d = interval_in_i;
      count_d    = '0;
    end else if (enable_i) begin
      count_d = wrap ? '0 : count_q + INTERVAL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      interval_q <= INTERVAL_W'(INTERVAL_DEF);
      count_q    <= '0;
    end else begin
      interval_q <= interval_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Snapshots NUM_CH channel words on each tick and writes them in order into per-channel
// ring buffers through the RAM's write-only ADC port.
module adc_sample_scheduler
  import adc_pkg::*;
#(
  parameter int                NUM_CH       = 2,
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 12,
  parameter int                DEPTH        = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
  parameter int                INTERVAL_W   = 18,
  parameter int                INTERVAL_DEF = DEF_INTERVAL
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       interval_we_i,
  input  logic [INTERVAL_W-1:0]      interval_in_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic                       wr_ready_i,
  output logic                       wr_en_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [DATA_W-1:0]          wr_data_o,
  output logic [NUM_CH*HEAD_W-1:0]   head_idx_o,
  output logic [NUM_CH-1:0]          overrun_o,
  input  logic                       overrun_clr_i,
  output logic                       busy_o
);

  localparam int DEPTH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("adc_sample_scheduler: NUM_CH must be in 1..8");
  end
  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("adc_sample_scheduler: DEPTH must be in 2..1024");
  end
  if (longint'(BASE_ADDR) + longint'(NUM_CH) * longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_range
    $error("adc_sample_scheduler: ring buffers exceed the RAM address space");
  end

  state_e                           state_q, state_d;
  logic [CH_W-1:0]                  ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0][DATA_W-1:0]    snap_q, snap_d;
  logic [NUM_CH-1:0][DEPTH_W-1:0]   wptr_q, wptr_d;
  logic [NUM_CH-1:0][HEAD_W-1:0]    head_q, head_d;
  logic [NUM_CH-1:0]                overrun_q, overrun_d, overrun_set;
  logic                             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]                wr_data_q, wr_data_d;
  logic                             tick;
  logic                             accept;

  sample_tick_gen #(
    .INTERVAL_W  (INTERVAL_W),
    .INTERVAL_DEF(INTERVAL_DEF)
  ) u_tick_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .interval_we_i(interval_we_i),
    .interval_in_i(interval_in_i),
    .tick_o       (tick)
  );

  function automatic logic [ADDR_W-1:0] slot_addr(input int ch, input logic [DEPTH_W-1:0] ptr);
    return BASE_ADDR + ADDR_W'(ch * DEPTH) + ADDR_W'(ptr);
  endfunction

  function automatic logic [DEPTH_W-1:0] next_ptr(input logic [DEPTH_W-1:0] ptr);
    return (ptr == DEPTH_W'(DEPTH - 1)) ? '0 : ptr + DEPTH_W'(1);
  endfunction

  // The write port registers are reloaded only on acceptance, so they stay stable while stalled.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    snap_d      = snap_q;
    wptr_d      = wptr_q;
    head_d      = head_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    overrun_set = '0;
    accept      = wr_en_q && wr_ready_i;

    unique case (state_q)
      IDLE: begin
        if (tick) state_d = SNAP;
      end
      SNAP: begin
        if (tick) overrun_set = '1;
        snap_d    = ch_data_i;
        ch_sel_d  = '0;
        wr_en_d   = 1'b1;
        wr_addr_d = slot_addr(0, wptr_q[0]);
        wr_data_d = ch_data_i[DATA_W-1:0];
        state_d   = WRITE;
      end
      WRITE: begin
        // A channel accepted in the same cycle as the lost tick is already safe.
        for (int k = 0; k < NUM_CH; k++) begin
          if (tick && (k > int'(ch_sel_q) || (k == int'(ch_sel_q) && !accept))) begin
            overrun_set[k] = 1'b1;
          end
        end
        if (accept) begin
          head_d[ch_sel_q] = HEAD_W'(wptr_q[ch_sel_q]);
          wptr_d[ch_sel_q] = next_ptr(wptr_q[ch_sel_q]);
          if (ch_sel_q == CH_W'(NUM_CH - 1)) begin
            wr_en_d = 1'b0;
            state_d = IDLE;
          end else begin
            ch_sel_d  = ch_sel_q + CH_W'(1);
            wr_addr_d = slot_addr(int'(ch_sel_d), wptr_q[ch_sel_d]);
            wr_data_d = snap_q[ch_sel_d];
          end
        end
      end
      default: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    overrun_d = (overrun_clr_i ? '0 : overrun_q) | overrun_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ch_sel_q  <= '0;
      snap_q    <= '0;
      wptr_q    <= '0;
      head_q    <= '0;
      overrun_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_sel_q  <= ch_sel_d;
      snap_q    <= snap_d;
      wptr_q    <= wptr_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign head_idx_o = head_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: NUM_CH=2, DEPTH=4, base 0x800, tick interval 8.
module tb_adc_sample_scheduler;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        intervalWe;
  logic [17:0] intervalIn;
  logic [63:0] chData;
  logic        wrReady;
  logic        wrEn;
  logic [11:0] wrAddr;
  logic [31:0] wrData;
  logic [19:0] headIdx;
  logic [1:0]  overrun;
  logic        ovrClr;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int base        = 0;

  logic [11:0] logAddr[$];
  logic [31:0] logData[$];
  int          logCyc[$];

  adc_sample_scheduler #(
    .NUM_CH      (2),
    .DATA_W      (32),
    .ADDR_W      (12),
    .DEPTH       (4),
    .BASE_ADDR   (12'h800),
    .INTERVAL_W  (18),
    .INTERVAL_DEF(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .enable_i     (enable),
    .interval_we_i(intervalWe),
    .interval_in_i(intervalIn),
    .ch_data_i    (chData),
    .wr_ready_i   (wrReady),
    .wr_en_o      (wrEn),
    .wr_addr_o    (wrAddr),
    .wr_data_o    (wrData),
    .head_idx_o   (headIdx),
    .overrun_o    (overrun),
    .overrun_clr_i(ovrClr),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted write is logged mid-cycle with the cycle it happened in.
  always @(negedge clk) begin
    if (rstN && wrEn && wrReady) begin
      logAddr.push_back(wrAddr);
      logData.push_back(wrData);
      logCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [63:0] data);
    wrReady = ready;
    chData  = data;
  endtask

  task automatic waitLog(input int count, input string tag);
    int n = 0;
    while (logAddr.size() < count && n < 100) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_logcount"}, 64'(logAddr.size()), 64'(count));
  endtask

  task automatic waitWrEn(input string tag);
    int n = 0;
    while (wrEn !== 1'b1 && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_wren_seen"}, 64'(wrEn), 64'd1);
  endtask

  task automatic waitSnap(input string tag);
    int n = 0;
    while (!(busy === 1'b1 && wrEn === 1'b0) && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput({tag, "_snap_seen"}, 64'(busy && !wrEn), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wr_en"},   64'(wrEn),    64'd0);
    checkOutput({tag, "_wr_addr"}, 64'(wrAddr),  64'd0);
    checkOutput({tag, "_wr_data"}, 64'(wrData),  64'd0);
    checkOutput({tag, "_head"},    64'(headIdx), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
    checkOutput({tag, "_busy"},    64'(busy),    64'd0);
  endtask

  initial begin
    rstN       = 1'b0;
    enable     = 1'b0;
    intervalWe = 1'b0;
    intervalIn = '0;
    ovrClr     = 1'b0;
    applyStimulus(1'b1, {32'hB, 32'hA});
    waitCycles(3);
    checkResetState("reset");

    // First sweep: tick at cycle 7, writes at 9 and 10.
    rstN   = 1'b1;
    enable = 1'b1;
    base   = cyc;
    waitLog(2, "t1");
    checkOutput("t1_addr0", 64'(logAddr[0]), 64'h800);
    checkOutput("t1_data0", 64'(logData[0]), 64'hA);
    checkOutput("t1_cyc0",  64'(logCyc[0] - base), 64'd9);
    checkOutput("t1_addr1", 64'(logAddr[1]), 64'h804);
    checkOutput("t1_data1", 64'(logData[1]), 64'hB);
    checkOutput("t1_cyc1",  64'(logCyc[1] - base), 64'd10);
    checkOutput("t1_head",  64'(headIdx), 64'd0);
    checkOutput("t1_idle_wren", 64'(wrEn), 64'd0);

    // Five ticks total: slot 3 then wrap back to slot 0.
    waitLog(8, "t2a");
    checkOutput("t2_head_slot3", 64'(headIdx), 64'({10'd3, 10'd3}));
    waitLog(10, "t2b");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_ch0_addr%0d", i), 64'(logAddr[2*i]),   64'(12'h800 + 12'(i % 4)));
      checkOutput($sformatf("t2_ch1_addr%0d", i), 64'(logAddr[2*i+1]), 64'(12'h804 + 12'(i % 4)));
    end
    checkOutput("t2_cyc_tick5", 64'(logCyc[8] - base), 64'd41);
    checkOutput("t2_head_wrap", 64'(headIdx), 64'd0);

    // Stall the ch0 write for 3 cycles.
    waitWrEn("t3");
    wrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_hold_addr%0d", i), 64'(wrAddr), 64'h801);
      checkOutput($sformatf("t3_hold_data%0d", i), 64'(wrData), 64'hA);
      checkOutput($sformatf("t3_hold_en%0d", i),   64'(wrEn),   64'd1);
      waitCycles(1);
    end
    wrReady = 1'b1;
    waitLog(12, "t3");
    checkOutput("t3_addr_ch0", 64'(logAddr[10]), 64'h801);
    checkOutput("t3_data_ch0", 64'(logData[10]), 64'hA);
    checkOutput("t3_cyc_ch0",  64'(logCyc[10] - base), 64'd52);
    checkOutput("t3_addr_ch1", 64'(logAddr[11]), 64'h805);
    checkOutput("t3_b2b",      64'(logCyc[11] - logCyc[10]), 64'd1);

    // Stall for 12 cycles across a tick: the tick is lost and both channels flag overrun.
    waitWrEn("t4");
    wrReady = 1'b0;
    waitCycles(12);
    checkOutput("t4_overrun_set", 64'(overrun), 64'h3);
    checkOutput("t4_hold_addr",   64'(wrAddr),  64'h802);
    wrReady = 1'b1;
    waitLog(16, "t4");
    checkOutput("t4_addr_ch0",  64'(logAddr[12]), 64'h802);
    checkOutput("t4_cyc_ch0",   64'(logCyc[12] - base), 64'd69);
    checkOutput("t4_addr_ch1",  64'(logAddr[13]), 64'h806);
    checkOutput("t4_next_ch0",  64'(logAddr[14]), 64'h803);
    checkOutput("t4_next_cyc",  64'(logCyc[14] - base), 64'd73);
    checkOutput("t4_next_ch1",  64'(logAddr[15]), 64'h807);
    checkOutput("t4_overrun_sticky", 64'(overrun), 64'h3);
    ovrClr = 1'b1;
    waitCycles(1);
    ovrClr = 1'b0;
    checkOutput("t4_overrun_clr", 64'(overrun), 64'h0);

    // Data changed right after SNAP must not leak into the sweep.
    applyStimulus(1'b1, {32'h22, 32'h11});
    waitSnap("t5");
    waitCycles(1);
    applyStimulus(1'b1, {32'hDEADBEEF, 32'hCAFEF00D});
    waitLog(18, "t5");
    checkOutput("t5_addr_ch0", 64'(logAddr[16]), 64'h800);
    checkOutput("t5_data_ch0", 64'(logData[16]), 64'h11);
    checkOutput("t5_addr_ch1", 64'(logAddr[17]), 64'h804);
    checkOutput("t5_data_ch1", 64'(logData[17]), 64'h22);
    checkOutput("t5_head",     64'(headIdx), 64'd0);

    // Reset mid-WRITE clears everything asynchronously.
    waitWrEn("t6");
    wrReady = 1'b0;
    #1;
    rstN = 1'b0;
    #1;
    checkResetState("t6_midreset");
    wrReady = 1'b1;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    base = cyc;

    // Interval load at count 3: next tick exactly 3 cycles after the load.
    waitCycles(3);
    intervalWe = 1'b1;
    intervalIn = 18'd3;
    waitCycles(1);
    intervalWe = 1'b0;
    waitCycles(2);
    checkOutput("t6_busy_before_tick", 64'(busy), 64'd0);
    waitCycles(1);
    checkOutput("t6_busy_snap", 64'(busy), 64'd1);
    waitLog(19, "t6");
    enable = 1'b0;
    checkOutput("t6_addr_ch0", 64'(logAddr[18]), 64'h800);
    checkOutput("t6_data_ch0", 64'(logData[18]), 64'hCAFEF00D);
    checkOutput("t6_cyc_ch0",  64'(logCyc[18] - base), 64'd8);

    // Disabling mid-sweep lets the sweep finish and stops further ticks.
    waitCycles(20);
    checkOutput("t7_logcount", 64'(logAddr.size()), 64'd20);
    checkOutput("t7_addr_ch1", 64'(logAddr[19]), 64'h804);
    checkOutput("t7_data_ch1", 64'(logData[19]), 64'hDEADBEEF);
    checkOutput("t7_busy",     64'(busy), 64'd0);
    checkOutput("t7_wren",     64'(wrEn), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
